// File: rtl/alu_ctrl_seq_if.sv
// Request/operation bundle between the main decoder, alu_ctrl_seq and the ALU.
//
// Signals:
//   req_valid  requester -> block   request present
//   req_ready  block -> requester   block accepts a request this cycle
//   aluop      requester -> block   ALU op class from the main decoder
//   funct      requester -> block   R-type function field (FUNCT_W bits)
//   flush      requester -> block   synchronous abort of the current operation
//   op_valid   block -> ALU         operation output valid
//   operation  block -> ALU         registered 4-bit ALU operation code
//   busy       block -> stall logic operation in flight
//   done       block -> stall logic one-cycle pulse on the final cycle of an operation
//   illegal    block -> trap logic  undefined funct flag (0 unless the trap option is built)
//
// Modports: master = requester side, slave = alu_ctrl_seq side.
interface alu_ctrl_seq_if #(
  parameter int unsigned FUNCT_W = 4
);
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         aluop;
  logic [FUNCT_W-1:0] funct;
  logic               flush;
  logic               op_valid;
  logic [3:0]         operation;
  logic               busy;
  logic               done;
  logic               illegal;

  modport master (
    output req_valid,
    output aluop,
    output funct,
    output flush,
    input  req_ready,
    input  op_valid,
    input  operation,
    input  busy,
    input  done,
    input  illegal
  );

  modport slave (
    input  req_valid,
    input  aluop,
    input  funct,
    input  flush,
    output req_ready,
    output op_valid,
    output operation,
    output busy,
    output done,
    output illegal
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Sequenced ALU control. Decodes aluop/funct into a 4-bit ALU operation code on request
// accept, then holds that code for the operation's latency (mult MUL_CYC, div DIV_CYC,
// swap 2, everything else 1 cycle). A new request may be taken on the final cycle of the
// current one, so back-to-back operations issue without a bubble.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_ctrl_seq_if.slave: req_valid/req_ready handshake, aluop, funct, flush,
//          op_valid, operation, busy, done, illegal
//
// Optional build macro ALUCTL_ILLEGAL_TRAP_EN: an aluop=11 request with an undefined
// funct[3:0] or any nonzero funct[FUNCT_W-1:4] issues as a 1-cycle no-op with illegal set.
// Without it, illegal is 0, undefined funct decodes to add and upper funct bits are ignored.
// FUNCT_W must be at least 4.
module alu_ctrl_seq #(
  parameter int unsigned FUNCT_W = 4,
  parameter int unsigned MUL_CYC = 4,
  parameter int unsigned DIV_CYC = 8
) (
  input logic          clk,
  input logic          rst_n,
  alu_ctrl_seq_if.slave bus
);

  localparam int unsigned MaxMd  = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int unsigned MaxCyc = (MaxMd > 2) ? MaxMd : 2;
  localparam int unsigned CNT_W  = $clog2(MaxCyc);

  // Counter load values are latency-1.
  localparam logic [CNT_W-1:0] MulCnt  = CNT_W'(MUL_CYC - 1);
  localparam logic [CNT_W-1:0] DivCnt  = CNT_W'(DIV_CYC - 1);
  localparam logic [CNT_W-1:0] SwapCnt = CNT_W'(1);

  localparam logic [3:0] OpNop  = 4'b0000;
  localparam logic [3:0] OpAdd  = 4'b0001;
  localparam logic [3:0] OpSub  = 4'b0010;
  localparam logic [3:0] OpMul  = 4'b0011;
  localparam logic [3:0] OpDiv  = 4'b0100;
  localparam logic [3:0] OpMove = 4'b0101;
  localparam logic [3:0] OpSwap = 4'b0110;
  localparam logic [3:0] OpAnd  = 4'b0111;
  localparam logic [3:0] OpOr   = 4'b1000;
  localparam logic [3:0] OpCmp  = 4'b1001;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;

  logic [FUNCT_W-1:0] funct;
  logic [1:0]         aluop;
  logic [3:0]         dec_op;
  logic [CNT_W-1:0]   dec_cnt;
  logic               funct_undef;
  logic               last;
  logic               req_ready;
  logic               accept;

  assign funct = bus.funct;
  assign aluop = bus.aluop;

  //////////////
  // Decoder  //
  //////////////

`ifdef ALUCTL_ILLEGAL_TRAP_EN
  logic funct_hi_nz;
  logic dec_ill;

  if (FUNCT_W > 4) begin : g_funct_hi
    assign funct_hi_nz = |funct[FUNCT_W-1:4];
  end else begin : g_no_funct_hi
    assign funct_hi_nz = 1'b0;
  end
`endif

  always_comb begin
    dec_op      = OpAdd;
    dec_cnt     = '0;
    funct_undef = 1'b0;
    case (aluop)
      2'b11: begin
        case (funct[3:0])
          4'b0000: dec_op = OpAdd;
          4'b0010: dec_op = OpSub;
          4'b0100: begin
            dec_op  = OpMul;
            dec_cnt = MulCnt;
          end
          4'b0101: begin
            dec_op  = OpDiv;
            dec_cnt = DivCnt;
          end
          4'b0111: dec_op = OpMove;
          4'b1000: begin
            dec_op  = OpSwap;
            dec_cnt = SwapCnt;
          end
          4'b1010: dec_op = OpAnd;
          4'b1011: dec_op = OpOr;
          default: begin
            dec_op      = OpAdd;
            funct_undef = 1'b1;
          end
        endcase
      end
      2'b10:   dec_op = OpAdd;  // load/store address add
      2'b01:   dec_op = OpCmp;  // branch compare
      default: dec_op = OpNop;  // jump/halt
    endcase
`ifdef ALUCTL_ILLEGAL_TRAP_EN
    dec_ill = (aluop == 2'b11) && (funct_undef || funct_hi_nz);
    if (dec_ill) begin
      dec_op  = OpNop;
      dec_cnt = '0;
    end
`endif
  end

  //////////////////////
  // Handshake + FSM  //
  //////////////////////

  assign last      = (state_q == StRun) && (cnt_q == '0);
  // flush blocks acceptance so a same-cycle request is never lost into an aborted slot.
  assign req_ready = !bus.flush && ((state_q == StIdle) || last);
  assign accept    = bus.req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (bus.flush) begin
      state_d = StIdle;
      cnt_d   = '0;
      op_d    = OpNop;
    end else if (accept) begin
      // Covers both IDLE and the last RUN cycle (back-to-back issue).
      state_d = StRun;
      cnt_d   = dec_cnt;
      op_d    = dec_op;
    end else if (state_q == StRun) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        state_d = StIdle;
        op_d    = OpNop;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpNop;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  ////////////////////
  // Illegal flag   //
  ////////////////////

`ifdef ALUCTL_ILLEGAL_TRAP_EN
  logic ill_q, ill_d;

  always_comb begin
    ill_d = ill_q;
    if (bus.flush) begin
      ill_d = 1'b0;
    end else if (accept) begin
      ill_d = dec_ill;
    end else if (last) begin
      ill_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_q <= 1'b0;
    end else begin
      ill_q <= ill_d;
    end
  end

  assign bus.illegal = ill_q;
`else
  logic unused_funct;
  assign unused_funct = ^{funct, funct_undef};
  assign bus.illegal  = 1'b0;
`endif

  /////////////
  // Outputs //
  /////////////

  assign bus.req_ready = req_ready;
  assign bus.op_valid  = (state_q == StRun);
  assign bus.busy      = (state_q == StRun);
  assign bus.operation = op_q;
  assign bus.done      = last && !bus.flush;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: reset check, a table of single requests, hand-written multi-cycle
// sequences (back-to-back, flush, reset mid-div) and a random phase. Every cycle the DUT is
// compared against a model that keeps a queue of per-cycle expected {illegal, operation}
// entries: an accepted request pushes one entry per cycle of its latency.
module tb_alu_ctrl_seq;
  localparam int unsigned MulCyc = 4;
  localparam int unsigned DivCyc = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.FUNCT_W(4)) bus ();

  alu_ctrl_seq #(
    .FUNCT_W(4),
    .MUL_CYC(MulCyc),
    .DIV_CYC(DivCyc)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];  // {illegal, operation} per upcoming RUN cycle

  logic       s_valid, s_ready, s_done, s_busy, s_ill;
  logic [3:0] s_op;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference decode straight from the opcode table.
  function automatic void ref_decode(input logic [1:0] a, input logic [3:0] f,
                                     output logic [3:0] op, output int lat,
                                     output logic ill);
    ill = 1'b0;
    lat = 1;
    op  = 4'b0001;
    if (a == 2'b11) begin
      case (f)
        4'b0000: op = 4'b0001;
        4'b0010: op = 4'b0010;
        4'b0100: begin op = 4'b0011; lat = MulCyc; end
        4'b0101: begin op = 4'b0100; lat = DivCyc; end
        4'b0111: op = 4'b0101;
        4'b1000: begin op = 4'b0110; lat = 2; end
        4'b1010: op = 4'b0111;
        4'b1011: op = 4'b1000;
        default: begin
`ifdef ALUCTL_ILLEGAL_TRAP_EN
          op  = 4'b0000;
          ill = 1'b1;
`else
          op = 4'b0001;
`endif
        end
      endcase
    end else if (a == 2'b10) begin
      op = 4'b0001;
    end else if (a == 2'b01) begin
      op = 4'b1001;
    end else begin
      op = 4'b0000;
    end
  endfunction

  // One clock cycle: drive, sample and compare against the model, then advance the model.
  task automatic step(input logic v, input logic [1:0] a, input logic [3:0] f,
                      input logic fl);
    logic [3:0] op;
    int         lat;
    logic       ill;
    logic       acc;
    int         n;
    @(negedge clk);
    bus.req_valid = v;
    bus.aluop     = a;
    bus.funct     = f;
    bus.flush     = fl;
    #1;
    s_valid = bus.op_valid;
    s_ready = bus.req_ready;
    s_done  = bus.done;
    s_busy  = bus.busy;
    s_ill   = bus.illegal;
    s_op    = bus.operation;
    n = exp_q.size();
    chk("op_valid", {7'd0, s_valid}, {7'd0, n > 0});
    chk("busy", {7'd0, s_busy}, {7'd0, n > 0});
    chk("operation", {4'd0, s_op}, (n > 0) ? {4'd0, exp_q[0][3:0]} : 8'd0);
    chk("illegal", {7'd0, s_ill}, (n > 0) ? {7'd0, exp_q[0][4]} : 8'd0);
    chk("done", {7'd0, s_done}, {7'd0, (n == 1) && !fl});
    chk("req_ready", {7'd0, s_ready}, {7'd0, !fl && (n <= 1)});
    acc = v && !fl && (n <= 1);
    ref_decode(a, f, op, lat, ill);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (n > 0) void'(exp_q.pop_front());
      if (acc) for (int i = 0; i < lat; i++) exp_q.push_back({ill, op});
    end
  endtask

  typedef struct {
    logic [1:0] aluop;
    logic [3:0] funct;
    logic [3:0] exp_op;
    int         lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{2'b11, 4'b0000, 4'b0001, 1};
    vecs[1]  = '{2'b11, 4'b0010, 4'b0010, 1};
    vecs[2]  = '{2'b11, 4'b0100, 4'b0011, MulCyc};
    vecs[3]  = '{2'b11, 4'b0101, 4'b0100, DivCyc};
    vecs[4]  = '{2'b11, 4'b0111, 4'b0101, 1};
    vecs[5]  = '{2'b11, 4'b1000, 4'b0110, 2};
    vecs[6]  = '{2'b11, 4'b1010, 4'b0111, 1};
    vecs[7]  = '{2'b11, 4'b1011, 4'b1000, 1};
`ifdef ALUCTL_ILLEGAL_TRAP_EN
    vecs[8]  = '{2'b11, 4'b1111, 4'b0000, 1};
`else
    vecs[8]  = '{2'b11, 4'b1111, 4'b0001, 1};
`endif
    vecs[9]  = '{2'b10, 4'b0101, 4'b0001, 1};
    vecs[10] = '{2'b01, 4'b0100, 4'b1001, 1};
    vecs[11] = '{2'b00, 4'b0000, 4'b0000, 1};

    bus.req_valid = 1'b0;
    bus.aluop     = 2'b00;
    bus.funct     = 4'b0000;
    bus.flush     = 1'b0;

    // Reset state
    #2;
    chk("rst_op_valid", {7'd0, bus.op_valid}, 8'd0);
    chk("rst_operation", {4'd0, bus.operation}, 8'd0);
    chk("rst_done", {7'd0, bus.done}, 8'd0);
    chk("rst_illegal", {7'd0, bus.illegal}, 8'd0);
    chk("rst_req_ready", {7'd0, bus.req_ready}, 8'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: single request, then hold through latency and one idle cycle
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].aluop, vecs[i].funct, 1'b0);
      for (int k = 0; k < vecs[i].lat; k++) begin
        step(1'b0, 2'b00, 4'b0000, 1'b0);
        chk("tbl_op", {4'd0, s_op}, {4'd0, vecs[i].exp_op});
        chk("tbl_done", {7'd0, s_done}, {7'd0, k == vecs[i].lat - 1});
        chk("tbl_ready", {7'd0, s_ready}, {7'd0, k == vecs[i].lat - 1});
      end
      step(1'b0, 2'b00, 4'b0000, 1'b0);
      chk("tbl_after_op", {4'd0, s_op}, 8'd0);
      chk("tbl_after_valid", {7'd0, s_valid}, 8'd0);
    end

    // Back-to-back: mult, then branch compare presented on mult's last cycle
    step(1'b1, 2'b11, 4'b0100, 1'b0);
    for (int k = 0; k < MulCyc; k++) begin
      if (k == MulCyc - 1) step(1'b1, 2'b01, 4'b0000, 1'b0);
      else step(1'b0, 2'b00, 4'b0000, 1'b0);
      chk("b2b_mul_op", {4'd0, s_op}, 8'h03);
    end
    step(1'b0, 2'b00, 4'b0000, 1'b0);
    chk("b2b_cmp_op", {4'd0, s_op}, 8'h09);
    chk("b2b_cmp_done", {7'd0, s_done}, 8'd1);
    step(1'b0, 2'b00, 4'b0000, 1'b0);

    // Flush on cycle 2 of swap with a competing request
    step(1'b1, 2'b11, 4'b1000, 1'b0);
    step(1'b0, 2'b00, 4'b0000, 1'b0);
    chk("fl_swap_c1", {4'd0, s_op}, 8'h06);
    step(1'b1, 2'b11, 4'b0000, 1'b1);
    chk("fl_done", {7'd0, s_done}, 8'd0);
    chk("fl_ready", {7'd0, s_ready}, 8'd0);
    step(1'b0, 2'b00, 4'b0000, 1'b0);
    chk("fl_after_op", {4'd0, s_op}, 8'd0);
    chk("fl_after_valid", {7'd0, s_valid}, 8'd0);

    // Reset mid-div
    step(1'b1, 2'b11, 4'b0101, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 2'b00, 4'b0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rmd_op_valid", {7'd0, bus.op_valid}, 8'd0);
    chk("rmd_busy", {7'd0, bus.busy}, 8'd0);
    chk("rmd_operation", {4'd0, bus.operation}, 8'd0);
    chk("rmd_done", {7'd0, bus.done}, 8'd0);
    chk("rmd_req_ready", {7'd0, bus.req_ready}, 8'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the queue model
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 1) == 1, 2'($urandom), 4'($urandom),
           $urandom_range(0, 11) == 0);
    end
    step(1'b0, 2'b00, 4'b0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
